// File: rtl/latency_credit_buffer.sv
// latency_credit_buffer: credit-gated response buffer wrapped around a fixed-latency,
// non-stallable pipeline. A request may enter the pipeline only while a FIFO slot is
// reserved for its response, so every response that comes back has somewhere to land.
module latency_credit_buffer #(
  parameter int unsigned Depth = 4,
  parameter type dtype = logic
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  output logic                         issue_o,
  input  logic                         resp_valid_i,
  input  dtype                         resp_data_i,
  output logic                         valid_o,
  output dtype                         data_o,
  input  logic                         ready_i,
  output logic [$clog2(Depth+1)-1:0]   outstanding_o,
  output logic                         overflow_o
);

  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  typedef logic [CntW-1:0] cnt_t;
  typedef logic [PtrW-1:0] ptr_t;

  localparam cnt_t DepthCnt = cnt_t'(Depth);
  localparam ptr_t LastPtr  = ptr_t'(Depth - 1);

  // Slot accounting: credits (free), outstanding (in the pipeline), count (in the FIFO).
  cnt_t credits_q;
  cnt_t outstanding_q;
  cnt_t count_q;
  ptr_t rd_ptr_q;
  ptr_t wr_ptr_q;
  logic overflow_q;
  dtype mem_q [Depth];

  logic issue;
  logic pop;
  logic resp_err;
  logic resp_ok;

  // Pointers wrap at Depth-1 so non-power-of-two depths work.
  function automatic ptr_t next_ptr(input ptr_t p);
    return (p == LastPtr) ? '0 : p + ptr_t'(1);
  endfunction

  // Request side depends only on registered credits, never on ready_i.
  assign issue = req_valid_i && (credits_q != '0);
  assign pop   = (count_q != '0) && ready_i;

  // A response is illegal if nothing is outstanding, or if the FIFO is full and
  // no slot frees up in the same cycle; such a response is dropped and flagged.
  assign resp_err = resp_valid_i &&
                    ((outstanding_q == '0) || ((count_q == DepthCnt) && !pop));
  assign resp_ok  = resp_valid_i && !resp_err;

  // Counters, pointers and the sticky error flag.
  // NOTE: non-blocking assignments here so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      credits_q     <= DepthCnt;
      outstanding_q <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      overflow_q    <= 1'b0;
    end else begin
      outstanding_q <= outstanding_q + cnt_t'(issue) - cnt_t'(resp_ok);
      if (resp_err) begin
        overflow_q <= 1'b1;
      end
      if (flush_i) begin
        // Flush wins over a same-cycle pop; a same-cycle issue still takes its credit.
        credits_q <= DepthCnt - cnt_t'(issue);
        count_q   <= '0;
        rd_ptr_q  <= '0;
        wr_ptr_q  <= '0;
      end else begin
        credits_q <= credits_q + cnt_t'(pop) - cnt_t'(issue);
        count_q   <= count_q + cnt_t'(resp_ok) - cnt_t'(pop);
        if (pop) begin
          rd_ptr_q <= next_ptr(rd_ptr_q);
        end
        if (resp_ok) begin
          wr_ptr_q <= next_ptr(wr_ptr_q);
        end
      end
    end
  end

  // Response storage, written only when a legal response arrives.
  // NOTE: storage has no reset; valid_o qualifies data_o, so stale contents are never consumed.
  always_ff @(posedge clk_i) begin
    if (resp_ok) begin
      mem_q[wr_ptr_q] <= resp_data_i;
    end
  end

  assign req_ready_o   = (credits_q != '0);
  assign issue_o       = issue;
  assign valid_o       = (count_q != '0);
  assign data_o        = mem_q[rd_ptr_q];
  assign outstanding_o = outstanding_q;
  assign overflow_o    = overflow_q;

  // Flushing with responses still in flight would orphan them.
  a_flush_idle : assert property (@(posedge clk_i) disable iff (!rst_ni)
    flush_i |-> (outstanding_q == '0));

  // Every slot is always exactly one of free, in flight, or buffered.
  a_slot_sum : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (32'(credits_q) + 32'(outstanding_q) + 32'(count_q)) == Depth);

endmodule

// File: tb/tb_latency_credit_buffer.sv
// tb_latency_credit_buffer: two buffers (Depth=4 and Depth=3) each wrapped around a
// 2-cycle delay-line pipeline, sharing one directed stimulus. A queue-based model
// predicts outputs every cycle; directed literals pin the model's behaviour.
module tb_latency_credit_buffer;

  localparam int DEP [2] = '{4, 3};

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic req_valid;
  logic ready;
  logic inj;

  logic       req_ready [2];
  logic       issue     [2];
  logic       valid     [2];
  logic       ovf       [2];
  logic [7:0] data      [2];
  logic       rv        [2];
  logic [7:0] rd        [2];
  logic [2:0] out0;
  logic [1:0] out1;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: in-flight count, FIFO contents, sticky error flag.
  int         m_out [2];
  logic [7:0] m_q   [2][$];
  bit         m_ovf [2];

  always #5 clk = ~clk;

  latency_credit_buffer #(.Depth(4), .dtype(logic [7:0])) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready[0]), .issue_o(issue[0]),
    .resp_valid_i(rv[0]), .resp_data_i(rd[0]),
    .valid_o(valid[0]), .data_o(data[0]), .ready_i(ready),
    .outstanding_o(out0), .overflow_o(ovf[0])
  );

  latency_credit_buffer #(.Depth(3), .dtype(logic [7:0])) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready[1]), .issue_o(issue[1]),
    .resp_valid_i(rv[1]), .resp_data_i(rd[1]),
    .valid_o(valid[1]), .data_o(data[1]), .ready_i(ready),
    .outstanding_o(out1), .overflow_o(ovf[1])
  );

  // Two-stage delay-line pipeline per buffer; request payload is a running issue count.
  for (genvar g = 0; g < 2; g++) begin : g_pipe
    logic       pv1, pv2;
    logic [7:0] pd1, pd2, req_data;
    assign rv[g] = pv2 | inj;
    assign rd[g] = inj ? 8'hEE : pd2;
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pv1 <= 1'b0; pv2 <= 1'b0; pd1 <= '0; pd2 <= '0; req_data <= '0;
      end else begin
        pv1 <= issue[g];
        pd1 <= req_data;
        pv2 <= pv1;
        pd2 <= pd1;
        if (issue[g]) req_data <= req_data + 8'd1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: free slots are whatever is neither in flight nor buffered.
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_out[i] = 0;
        m_q[i].delete();
        m_ovf[i] = 1'b0;
      end else begin
        int  free_m;
        bit  iss_m, pop_m, err_m;
        free_m = DEP[i] - m_out[i] - m_q[i].size();
        iss_m  = req_valid && (free_m > 0);
        pop_m  = ready && (m_q[i].size() > 0);
        err_m  = rv[i] && ((m_out[i] == 0) || ((m_q[i].size() == DEP[i]) && !pop_m));
        if (flush) m_q[i].delete();
        else if (pop_m) void'(m_q[i].pop_front());
        if (rv[i] && !err_m) begin
          m_q[i].push_back(rd[i]);
          m_out[i]--;
        end
        if (err_m) m_ovf[i] = 1'b1;
        if (iss_m) m_out[i]++;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int free_m;
      logic [31:0] act_out;
      free_m  = DEP[i] - m_out[i] - m_q[i].size();
      act_out = (i == 0) ? {29'b0, out0} : {30'b0, out1};
      check($sformatf("d%0d_req_ready", i), 32'(req_ready[i]), 32'(free_m != 0));
      check($sformatf("d%0d_issue", i), 32'(issue[i]), 32'(req_valid && (free_m != 0)));
      check($sformatf("d%0d_valid", i), 32'(valid[i]), 32'(m_q[i].size() != 0));
      if (m_q[i].size() != 0)
        check($sformatf("d%0d_data", i), 32'(data[i]), 32'(m_q[i][0]));
      check($sformatf("d%0d_outstanding", i), act_out, 32'(m_out[i]));
      check($sformatf("d%0d_overflow", i), 32'(ovf[i]), 32'(m_ovf[i]));
    end
  end

  initial begin
    int n_iss;
    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; ready = 1'b0; inj = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready[0]), 32'd1);
    check("rst_valid", 32'(valid[0]), 32'd0);
    check("rst_outstanding", 32'(out0), 32'd0);
    check("rst_overflow", 32'(ovf[0]), 32'd0);
    tick();
    rst_n = 1'b1;

    // Streaming: first response visible in cycle 3, then one word per cycle.
    for (int k = 0; k < 20; k++) begin
      req_valid = 1'b1; ready = 1'b1;
      @(negedge clk);
      check("stream_valid", 32'(valid[0]), 32'(k >= 3));
      if (k >= 3) check("stream_data", 32'(data[0]), 32'(k - 3));
      check("stream_req_ready", 32'(req_ready[0]), 32'd1);
      tick();
    end
    req_valid = 1'b0;
    for (int k = 20; k < 26; k++) begin
      @(negedge clk);
      check("tail_valid", 32'(valid[0]), 32'(k <= 22));
      if (k <= 22) check("tail_data", 32'(data[0]), 32'(k - 3));
      tick();
    end

    // Consumer stalled: exactly Depth issues, then one pop frees one issue.
    n_iss = 0;
    for (int k = 0; k < 8; k++) begin
      req_valid = 1'b1; ready = 1'b0;
      @(negedge clk);
      n_iss += int'(issue[0]);
      tick();
    end
    check("stall_issue_count", 32'(n_iss), 32'd4);
    @(negedge clk);
    check("stall_req_ready", 32'(req_ready[0]), 32'd0);
    check("stall_outstanding", 32'(out0), 32'd0);
    check("stall_head", 32'(data[0]), 32'd20);
    tick();
    ready = 1'b1;
    @(negedge clk);
    check("pop_cycle_issue", 32'(issue[0]), 32'd0);
    tick();
    ready = 1'b0;
    @(negedge clk);
    check("post_pop_issue", 32'(issue[0]), 32'd1);
    check("post_pop_head", 32'(data[0]), 32'd21);
    tick();
    req_valid = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    check("refill_req_ready", 32'(req_ready[0]), 32'd0);

    // Flush with nothing in flight empties both buffers.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("flush_valid", 32'(valid[0]), 32'd0);
    check("flush_req_ready", 32'(req_ready[0]), 32'd1);

    // Build count=2, credits=1, then issue and pop together.
    req_valid = 1'b1;
    repeat (2) tick();
    req_valid = 1'b0;
    repeat (3) tick();
    req_valid = 1'b1;
    tick();
    ready = 1'b1;
    @(negedge clk);
    check("simul_issue", 32'(issue[0]), 32'd1);
    check("simul_head", 32'(data[0]), 32'd25);
    tick();
    req_valid = 1'b0; ready = 1'b0;
    @(negedge clk);
    check("simul_credit_kept", 32'(req_ready[0]), 32'd1);
    check("simul_outstanding", 32'(out0), 32'd2);
    check("simul_next_head", 32'(data[0]), 32'd26);

    // Drain, then inject a response nobody asked for.
    ready = 1'b1;
    repeat (8) tick();
    @(negedge clk);
    check("drained_valid", 32'(valid[0]), 32'd0);
    check("pre_err_overflow", 32'(ovf[0]), 32'd0);
    ready = 1'b0;
    inj = 1'b1;
    tick();
    inj = 1'b0;
    @(negedge clk);
    check("err_overflow", 32'(ovf[0]), 32'd1);
    check("err_fifo_unchanged", 32'(valid[0]), 32'd0);
    repeat (3) tick();
    @(negedge clk);
    check("err_sticky", 32'(ovf[0]), 32'd1);

    // Random issue/pop bursts, mainly exercising the Depth=3 wrap.
    for (int b = 0; b < 10; b++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int c = 0; c < len; c++) begin
        req_valid = 1'($urandom_range(0, 1));
        ready     = 1'($urandom_range(0, 1));
        tick();
      end
    end
    req_valid = 1'b0; ready = 1'b1;
    repeat (10) tick();
    @(negedge clk);
    check("rand_drained", 32'(valid[1]), 32'd0);
    check("rand_outstanding", 32'(out1), 32'd0);

    // Reset with three entries buffered.
    ready = 1'b0; req_valid = 1'b1;
    repeat (3) tick();
    req_valid = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    check("prereset_valid", 32'(valid[0]), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("reset_valid", 32'(valid[0]), 32'd0);
    check("reset_req_ready", 32'(req_ready[0]), 32'd1);
    check("reset_outstanding", 32'(out0), 32'd0);
    check("reset_overflow", 32'(ovf[0]), 32'd0);
    tick();
    rst_n = 1'b1; req_valid = 1'b1;
    @(negedge clk);
    check("after_reset_issue", 32'(issue[0]), 32'd1);
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    check("after_reset_outstanding", 32'(out0), 32'd1);
    ready = 1'b1;
    repeat (6) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
